// File: rtl/core_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : core_pkg
//  Description : Shared integer-ALU encodings (funct3 selects, funct7 alt bit)
//  Revision    : 1.0 - initial release
// ============================================================================
package core_pkg;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [6:0] FUNCT7_ALT = 7'b0100000;

    // Bit of funct7 that selects SUB / SRA.
    localparam int ALT_BIT = 5;

endpackage : core_pkg
`default_nettype wire

// File: rtl/alu_pipe_if.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pipe_if
//  Description : Issue-side request / writeback-side response bundle for the
//                pipelined ALU. master = issuer + consumer, slave = ALU.
//  Revision    : 1.0 - initial release
// ============================================================================
interface alu_pipe_if #(
    parameter int XLEN  = 64,
    parameter int TAG_W = 5
);
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic             imm;
    logic             word;
    logic [2:0]       funct3;
    logic [6:0]       funct7;
    logic [XLEN-1:0]  op1;
    logic [XLEN-1:0]  op2;
    logic [TAG_W-1:0] tag_in;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  res;
    logic [TAG_W-1:0] tag_out;
    logic             illegal;

    modport master (
        output flush, in_valid, imm, word, funct3, funct7, op1, op2, tag_in,
               out_ready,
        input  in_ready, out_valid, res, tag_out, illegal
    );

    modport slave (
        input  flush, in_valid, imm, word, funct3, funct7, op1, op2, tag_in,
               out_ready,
        output in_ready, out_valid, res, tag_out, illegal
    );
endinterface : alu_pipe_if
`default_nettype wire

// File: rtl/alu_core.sv
`default_nettype none
// ============================================================================
//  Module      : alu_core
//  Description : Purely combinational RV32I/RV64I integer ALU covering
//                OP / OP-IMM / OP-32 / OP-IMM-32. Word mode only exists when
//                XLEN = 64; there it yields a sign-extended 32-bit result.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_core
    import core_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            imm,
    input  logic            word,
    input  logic [2:0]      funct3,
    input  logic [6:0]      funct7,
    input  logic [XLEN-1:0] op1,
    input  logic [XLEN-1:0] op2,
    output logic [XLEN-1:0] res,
    output logic            illegal
);

    logic                   w_alt;
    logic                   w_sub;
    logic [5:0]             w_shamt;
    logic signed [XLEN-1:0] w_sra;
    logic [XLEN-1:0]        w_srl;
    logic [XLEN-1:0]        w_full;
    logic                   w_word_sel;
    logic                   w_word_ill;
    logic [XLEN-1:0]        w_word_res;
    logic [5:0]             w_unused_f7;

    assign w_alt       = funct7[ALT_BIT];
    assign w_unused_f7 = {funct7[6], funct7[4:0]};
    // An immediate form never subtracts: ADDI has no funct7 field.
    assign w_sub       = !imm && w_alt;
    // Upper shift-amount bits are ignored; RV32 shifts by at most 31.
    assign w_shamt     = (XLEN == 64) ? op2[5:0] : {1'b0, op2[4:0]};
    // Kept in its own signed net so the arithmetic shift is not demoted to
    // a logical one by an unsigned operand in a surrounding ternary.
    assign w_sra       = $signed(op1) >>> w_shamt;
    assign w_srl       = op1 >> w_shamt;

    // Full-width operation select.
    always_comb begin
        w_full = '0;
        case (funct3)
            F3_ADD:  w_full = w_sub ? (op1 - op2) : (op1 + op2);
            F3_SLL:  w_full = op1 << w_shamt;
            F3_SLT:  w_full = {{(XLEN-1){1'b0}}, ($signed(op1) < $signed(op2))};
            F3_SLTU: w_full = {{(XLEN-1){1'b0}}, (op1 < op2)};
            F3_XOR:  w_full = op1 ^ op2;
            F3_SR:   w_full = w_alt ? w_sra : w_srl;
            F3_OR:   w_full = op1 | op2;
            F3_AND:  w_full = op1 & op2;
            default: w_full = '0;
        endcase
    end

    generate
        if (XLEN == 64) begin : g_word
            logic [31:0]        w_a;
            logic [31:0]        w_b;
            logic [4:0]         w_sh5;
            logic signed [31:0] w_sraw;
            logic [31:0]        w_lo;
            logic               w_ill;

            assign w_a    = op1[31:0];
            assign w_b    = op2[31:0];
            assign w_sh5  = op2[4:0];
            assign w_sraw = $signed(w_a) >>> w_sh5;

            // 32-bit operation select; only ADD/SUB, SLL, SRL/SRA exist as word ops.
            always_comb begin
                w_lo  = '0;
                w_ill = 1'b0;
                case (funct3)
                    F3_ADD:  w_lo = w_sub ? (w_a - w_b) : (w_a + w_b);
                    F3_SLL:  w_lo = w_a << w_sh5;
                    F3_SR:   w_lo = w_alt ? w_sraw : (w_a >> w_sh5);
                    default: w_ill = 1'b1;
                endcase
            end

            assign w_word_sel = word;
            assign w_word_ill = w_ill;
            assign w_word_res = {{32{w_lo[31]}}, w_lo};
        end else begin : g_noword
            logic w_unused_word;

            assign w_unused_word = word;
            assign w_word_sel    = 1'b0;
            assign w_word_ill    = 1'b0;
            assign w_word_res    = '0;
        end
    endgenerate

    // Final result mux: illegal word ops produce zero.
    always_comb begin
        res     = w_full;
        illegal = 1'b0;
        if (w_word_sel) begin
            illegal = w_word_ill;
            res     = w_word_ill ? '0 : w_word_res;
        end
    end

endmodule : alu_core
`default_nettype wire

// File: rtl/alu_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pipe
//  Description : Two-stage valid/ready wrapper around alu_core. S1 registers
//                the request, S2 registers the result. Full throughput,
//                backpressure-aware, flushable.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_pipe
    import core_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int TAG_W = 5
) (
    input  logic      CLK,
    input  logic      RST,
    alu_pipe_if.slave bus
);

    // S1: request register
    logic             r_v1;
    logic             r_imm;
    logic             r_word;
    logic [2:0]       r_funct3;
    logic [6:0]       r_funct7;
    logic [XLEN-1:0]  r_op1;
    logic [XLEN-1:0]  r_op2;
    logic [TAG_W-1:0] r_tag1;

    // S2: result register
    logic             r_v2;
    logic [XLEN-1:0]  r_res;
    logic [TAG_W-1:0] r_tag2;
    logic             r_illegal;

    logic             w_s2_ready;
    logic             w_s1_ready;
    logic             w_accept;
    logic             w_advance;
    logic [XLEN-1:0]  w_res;
    logic             w_illegal;

    // Ready depends only on registered state and out_ready, never in_valid.
    assign w_s2_ready = !r_v2 || bus.out_ready;
    assign w_s1_ready = !r_v1 || w_s2_ready;
    assign w_accept   = bus.in_valid && w_s1_ready;
    assign w_advance  = r_v1 && w_s2_ready;

    assign bus.in_ready  = w_s1_ready;
    assign bus.out_valid = r_v2;
    assign bus.res       = r_res;
    assign bus.tag_out   = r_tag2;
    assign bus.illegal   = r_illegal;

    alu_core #(
        .XLEN (XLEN)
    ) u_core (
        .imm     (r_imm),
        .word    (r_word),
        .funct3  (r_funct3),
        .funct7  (r_funct7),
        .op1     (r_op1),
        .op2     (r_op2),
        .res     (w_res),
        .illegal (w_illegal)
    );

    // Stage valid bits; flush wins over everything except reset.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_v1 <= 1'b0;
            r_v2 <= 1'b0;
        end else if (bus.flush) begin
            r_v1 <= 1'b0;
            r_v2 <= 1'b0;
        end else begin
            if (w_s2_ready) begin
                r_v2 <= r_v1;
            end
            if (w_s1_ready) begin
                r_v1 <= bus.in_valid;
            end
        end
    end

    // S1 payload capture on every accepted request.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_imm    <= 1'b0;
            r_word   <= 1'b0;
            r_funct3 <= '0;
            r_funct7 <= '0;
            r_op1    <= '0;
            r_op2    <= '0;
            r_tag1   <= '0;
        end else if (w_accept) begin
            r_imm    <= bus.imm;
            r_word   <= bus.word;
            r_funct3 <= bus.funct3;
            r_funct7 <= bus.funct7;
            r_op1    <= bus.op1;
            r_op2    <= bus.op2;
            r_tag1   <= bus.tag_in;
        end
    end

    // S2 payload: only moves when S1 holds an op and S2 can take it, so a
    // stalled result stays stable.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_res     <= '0;
            r_tag2    <= '0;
            r_illegal <= 1'b0;
        end else if (w_advance) begin
            r_res     <= w_res;
            r_tag2    <= r_tag1;
            r_illegal <= w_illegal;
        end
    end

endmodule : alu_pipe
`default_nettype wire

// File: tb/tb_alu_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_pipe
//  Description : Directed self-checking bench for alu_pipe (XLEN = 64).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_pipe;
    import core_pkg::*;

    localparam int XLEN  = 64;
    localparam int TAG_W = 5;

    logic CLK = 1'b0;
    logic RST = 1'b0;

    always #5 CLK = ~CLK;

    alu_pipe_if #(.XLEN(XLEN), .TAG_W(TAG_W)) bus ();

    alu_pipe #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0]  res;
    } out_t;

    out_t q[$];

    // Record every completed output transfer.
    always @(posedge CLK) begin
        if (!RST && bus.out_valid && bus.out_ready)
            q.push_back({bus.tag_out, bus.res});
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got running required finished");
        $fatal(1, "watchdog");
    end

    task automatic idle();
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.imm       = 1'b0;
        bus.word      = 1'b0;
        bus.funct3    = '0;
        bus.funct7    = '0;
        bus.op1       = '0;
        bus.op2       = '0;
        bus.tag_in    = '0;
        bus.out_ready = 1'b1;
    endtask

    task automatic drive_op(input logic [2:0] f3, input logic [6:0] f7,
                            input logic im, input logic wd,
                            input logic [63:0] a, input logic [63:0] b,
                            input logic [4:0] t);
        bus.funct3 = f3;
        bus.funct7 = f7;
        bus.imm    = im;
        bus.word   = wd;
        bus.op1    = a;
        bus.op2    = b;
        bus.tag_in = t;
    endtask

    // Issue one op into an empty pipe and return what appears two edges later.
    task automatic issue_one(input logic [2:0] f3, input logic [6:0] f7,
                             input logic im, input logic wd,
                             input logic [63:0] a, input logic [63:0] b,
                             input logic [4:0] t,
                             output logic v, output logic [63:0] r,
                             output logic [4:0] tg, output logic il);
        drive_op(f3, f7, im, wd, a, b, t);
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge CLK); #1;
        bus.in_valid = 1'b0;
        @(posedge CLK); #1;
        v  = bus.out_valid;
        r  = bus.res;
        tg = bus.tag_out;
        il = bus.illegal;
        @(posedge CLK); #1;
    endtask

    task automatic test_reset();
        idle();
        #1 RST = 1'b1;
        #2;
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b required 0", bus.out_valid); end
        n_cmp++; if (bus.res !== 64'h0) begin n_bad++; $display("FAIL reset_res: got %h required 0", bus.res); end
        n_cmp++; if (bus.tag_out !== 5'h0) begin n_bad++; $display("FAIL reset_tag: got %h required 0", bus.tag_out); end
        n_cmp++; if (bus.illegal !== 1'b0) begin n_bad++; $display("FAIL reset_illegal: got %b required 0", bus.illegal); end
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b required 1", bus.in_ready); end
        #9 RST = 1'b0;
        @(posedge CLK); #1;
    endtask

    task automatic test_add_overflow();
        logic v, il; logic [63:0] r; logic [4:0] tg;
        issue_one(F3_ADD, 7'h00, 1'b0, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 5'd3, v, r, tg, il);
        n_cmp++; if (v !== 1'b1) begin n_bad++; $display("FAIL add_valid: got %b required 1", v); end
        n_cmp++; if (r !== 64'h8000_0000_0000_0000) begin n_bad++; $display("FAIL add_wrap_res: got %h required 8000000000000000", r); end
        n_cmp++; if (tg !== 5'd3) begin n_bad++; $display("FAIL add_tag: got %0d required 3", tg); end
    endtask

    task automatic test_addi_vs_sub();
        logic v, il; logic [63:0] r; logic [4:0] tg;
        issue_one(F3_ADD, FUNCT7_ALT, 1'b1, 1'b0, 64'd10, 64'd3, 5'd4, v, r, tg, il);
        n_cmp++; if (r !== 64'd13) begin n_bad++; $display("FAIL addi_no_sub: got %0d required 13", r); end
        issue_one(F3_ADD, FUNCT7_ALT, 1'b0, 1'b0, 64'd10, 64'd3, 5'd5, v, r, tg, il);
        n_cmp++; if (r !== 64'd7) begin n_bad++; $display("FAIL sub: got %0d required 7", r); end
    endtask

    task automatic test_word();
        logic v, il; logic [63:0] r; logic [4:0] tg;
        issue_one(F3_ADD, 7'h00, 1'b0, 1'b1, 64'h7FFF_FFFF, 64'h1, 5'd6, v, r, tg, il);
        n_cmp++; if (r !== 64'hFFFF_FFFF_8000_0000) begin n_bad++; $display("FAIL addw: got %h required ffffffff80000000", r); end
        n_cmp++; if (il !== 1'b0) begin n_bad++; $display("FAIL addw_illegal: got %b required 0", il); end
        issue_one(F3_SR, FUNCT7_ALT, 1'b1, 1'b1, 64'h8000_0000, 64'h4, 5'd7, v, r, tg, il);
        n_cmp++; if (r !== 64'hFFFF_FFFF_F800_0000) begin n_bad++; $display("FAIL sraw: got %h required fffffffff8000000", r); end
        issue_one(F3_SR, 7'h00, 1'b1, 1'b1, 64'h8000_0000, 64'h4, 5'd8, v, r, tg, il);
        n_cmp++; if (r !== 64'h0000_0000_0800_0000) begin n_bad++; $display("FAIL srlw: got %h required 0000000008000000", r); end
        issue_one(F3_XOR, 7'h00, 1'b0, 1'b1, 64'h1234, 64'h5678, 5'd9, v, r, tg, il);
        n_cmp++; if (il !== 1'b1) begin n_bad++; $display("FAIL word_xor_illegal: got %b required 1", il); end
        n_cmp++; if (r !== 64'h0) begin n_bad++; $display("FAIL word_xor_res: got %h required 0", r); end
    endtask

    task automatic test_slt();
        logic v, il; logic [63:0] r; logic [4:0] tg;
        issue_one(F3_SLT, 7'h00, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 5'd10, v, r, tg, il);
        n_cmp++; if (r !== 64'd1) begin n_bad++; $display("FAIL slt: got %0d required 1", r); end
        issue_one(F3_SLTU, 7'h00, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 5'd11, v, r, tg, il);
        n_cmp++; if (r !== 64'd0) begin n_bad++; $display("FAIL sltu: got %0d required 0", r); end
        issue_one(F3_SR, FUNCT7_ALT, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 64'h44, 5'd12, v, r, tg, il);
        n_cmp++; if (r !== 64'hF800_0000_0000_0000) begin n_bad++; $display("FAIL sra64_shamt_mask: got %h required f800000000000000", r); end
    endtask

    task automatic test_back_to_back();
        logic [63:0] exp_res [4];
        int idx;
        logic acc;
        exp_res[0] = 64'h101; exp_res[1] = 64'h202;
        exp_res[2] = 64'h303; exp_res[3] = 64'h404;
        idx = 0;
        q.delete();
        for (int cyc = 0; cyc < 20; cyc++) begin
            bus.out_ready = (cyc < 2 || cyc >= 8);
            if (idx < 4) begin
                drive_op(F3_ADD, 7'h00, 1'b0, 1'b0, 64'h100 * 64'(idx + 1), 64'(idx + 1), 5'(idx + 1));
                bus.in_valid = 1'b1;
            end else begin
                bus.in_valid = 1'b0;
            end
            @(negedge CLK);
            acc = bus.in_valid && bus.in_ready;
            if (cyc == 4) begin
                n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL stall_in_ready: got %b required 0", bus.in_ready); end
            end
            if (cyc == 7) begin
                n_cmp++; if (bus.out_valid !== 1'b1) begin n_bad++; $display("FAIL stall_out_valid: got %b required 1", bus.out_valid); end
                n_cmp++; if (bus.tag_out !== 5'd1) begin n_bad++; $display("FAIL stall_tag_held: got %0d required 1", bus.tag_out); end
                n_cmp++; if (bus.res !== 64'h101) begin n_bad++; $display("FAIL stall_res_held: got %h required 101", bus.res); end
            end
            @(posedge CLK); #1;
            if (acc) idx++;
        end
        bus.in_valid = 1'b0;
        n_cmp++; if (q.size() !== 4) begin n_bad++; $display("FAIL b2b_count: got %0d required 4", q.size()); end
        for (int i = 0; i < 4 && i < q.size(); i++) begin
            n_cmp++;
            if (q[i].tag !== 5'(i + 1) || q[i].res !== exp_res[i]) begin
                n_bad++;
                $display("FAIL b2b_order[%0d]: got tag %0d res %h required tag %0d res %h", i, q[i].tag, q[i].res, i + 1, exp_res[i]);
            end
        end
    endtask

    task automatic test_flush();
        q.delete();
        bus.out_ready = 1'b0;
        drive_op(F3_ADD, 7'h00, 1'b0, 1'b0, 64'd1, 64'd1, 5'd20);
        bus.in_valid = 1'b1;
        @(posedge CLK); #1;
        drive_op(F3_ADD, 7'h00, 1'b0, 1'b0, 64'd2, 64'd2, 5'd21);
        @(posedge CLK); #1;
        drive_op(F3_ADD, 7'h00, 1'b0, 1'b0, 64'd3, 64'd3, 5'd22);
        bus.flush = 1'b1;
        @(negedge CLK);
        n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL flush_stall_in_ready: got %b required 0", bus.in_ready); end
        @(posedge CLK); #1;
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL flush_out_valid: got %b required 0", bus.out_valid); end
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL flush_in_ready: got %b required 1", bus.in_ready); end
        bus.out_ready = 1'b1;
        repeat (5) @(posedge CLK);
        #1;
        n_cmp++; if (q.size() !== 0) begin n_bad++; $display("FAIL flush_no_late_result: got %0d results required 0", q.size()); end
        // New op accepted in the flush cycle is dropped too.
        drive_op(F3_ADD, 7'h00, 1'b0, 1'b0, 64'd4, 64'd4, 5'd23);
        bus.in_valid = 1'b1;
        bus.flush    = 1'b1;
        @(negedge CLK);
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL flush_accept_in_ready: got %b required 1", bus.in_ready); end
        @(posedge CLK); #1;
        bus.in_valid = 1'b0;
        bus.flush    = 1'b0;
        repeat (4) @(posedge CLK);
        #1;
        n_cmp++; if (q.size() !== 0) begin n_bad++; $display("FAIL flush_drops_new_op: got %0d results required 0", q.size()); end
    endtask

    task automatic test_mid_reset();
        q.delete();
        drive_op(F3_ADD, 7'h00, 1'b0, 1'b0, 64'd5, 64'd6, 5'd9);
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b0;
        @(posedge CLK); #1;
        drive_op(F3_ADD, 7'h00, 1'b0, 1'b0, 64'd7, 64'd8, 5'd10);
        @(posedge CLK); #1;
        bus.in_valid = 1'b0;
        n_cmp++; if (bus.res !== 64'd11) begin n_bad++; $display("FAIL pre_reset_res: got %0d required 11", bus.res); end
        #2 RST = 1'b1;
        #1;
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL async_rst_out_valid: got %b required 0", bus.out_valid); end
        n_cmp++; if (bus.res !== 64'h0) begin n_bad++; $display("FAIL async_rst_res: got %h required 0", bus.res); end
        n_cmp++; if (bus.tag_out !== 5'h0) begin n_bad++; $display("FAIL async_rst_tag: got %0d required 0", bus.tag_out); end
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL async_rst_in_ready: got %b required 1", bus.in_ready); end
        #2 RST = 1'b0;
        bus.out_ready = 1'b1;
        repeat (5) @(posedge CLK);
        #1;
        n_cmp++; if (q.size() !== 0) begin n_bad++; $display("FAIL reset_discards: got %0d results required 0", q.size()); end
    endtask

    initial begin
        test_reset();
        test_add_overflow();
        test_addi_vs_sub();
        test_word();
        test_slt();
        test_back_to_back();
        test_flush();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_alu_pipe
`default_nettype wire
